// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and
// holds the fetched word for decode until it is consumed.
//
// state | meaning
// IDLE  | out of reset, first request issued on the next edge
// FETCH | request outstanding at pc, waiting for imem_ack
// HOLD  | instruction presented to decode, waiting for inst_ready
// ERR   | misaligned register target seen, halted until reset
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    input  logic [1:0]  npc_op,
    input  logic [31:0] rs_val,
    output logic        fetch_err
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERR} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        err_q, err_d;
    logic [31:0] seq_pc;
    logic [31:0] br_off;
    logic [31:0] npc;
    logic        bad_target;

    assign seq_pc     = pc_out_q + 32'd4;
    assign br_off     = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
    assign bad_target = (npc_op == 2'b11) && (rs_val[1:0] != 2'b00);

    always_comb begin
        npc = seq_pc;
        case (npc_op)
            2'b00: npc = seq_pc;
            2'b01: npc = seq_pc + br_off;
            2'b10: npc = {seq_pc[31:28], inst_q[25:0], 2'b00};
            2'b11: npc = rs_val;
            default: npc = seq_pc;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        pc_out_d = pc_out_q;
        err_d    = err_q;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    inst_d   = imem_rdata;
                    pc_out_d = pc_q;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (inst_ready) begin
                    // A faulting redirect leaves pc pointing at the offending instruction
                    if (bad_target) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end else begin
                        pc_d    = npc;
                        state_d = FETCH;
                    end
                end
            end
            ERR: state_d = ERR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            inst_q   <= 32'h0;
            pc_out_q <= RESET_PC;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            pc_out_q <= pc_out_d;
            err_q    <= err_d;
        end
    end

    assign imem_req   = (state_q == FETCH);
    assign imem_addr  = pc_q;
    assign inst_valid = (state_q == HOLD);
    assign inst       = inst_q;
    assign pc_out     = pc_out_q;
    assign pc_plus4   = seq_pc;
    assign fetch_err  = err_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a table of fetch transactions with hand-computed
// addresses, plus reset-during-FETCH/HOLD sequences.
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [1:0]  npc_op;
    logic [31:0] rs_val;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .pc_out     (pc_out),
        .pc_plus4   (pc_plus4),
        .npc_op     (npc_op),
        .rs_val     (rs_val),
        .fetch_err  (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          waits;
        logic [31:0] rdata;
        int          stall;
        logic [1:0]  op;
        logic [31:0] rs;
        logic [31:0] addr;
        bit          err;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        chk("req_at_fetch", {31'b0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, v.addr);
        for (int w = 0; w < v.waits; w++) begin
            imem_ack = 1'b0;
            step();
            chk("wait_addr_stable", imem_addr, v.addr);
            chk("wait_req_held", {31'b0, imem_req}, 32'd1);
            chk("wait_no_valid", {31'b0, inst_valid}, 32'd0);
        end
        imem_ack   = 1'b1;
        imem_rdata = v.rdata;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        chk("hold_valid", {31'b0, inst_valid}, 32'd1);
        chk("hold_no_req", {31'b0, imem_req}, 32'd0);
        chk("hold_inst", inst, v.rdata);
        chk("hold_pc_out", pc_out, v.addr);
        chk("hold_pc_plus4", pc_plus4, v.addr + 32'd4);
        for (int s = 0; s < v.stall; s++) begin
            inst_ready = 1'b0;
            imem_ack   = 1'b1;
            npc_op     = 2'b11;
            rs_val     = 32'h0000_0003;
            step();
            chk("stall_inst", inst, v.rdata);
            chk("stall_pc_out", pc_out, v.addr);
            chk("stall_no_req", {31'b0, imem_req}, 32'd0);
            chk("stall_valid", {31'b0, inst_valid}, 32'd1);
        end
        imem_ack   = 1'b0;
        inst_ready = 1'b1;
        npc_op     = v.op;
        rs_val     = v.rs;
        step();
        inst_ready = 1'b0;
        npc_op     = 2'b00;
        rs_val     = 32'h0;
        chk("valid_one_shot", {31'b0, inst_valid}, 32'd0);
        chk("fetch_err_flag", {31'b0, fetch_err}, {31'b0, v.err});
    endtask

    initial begin
        vecs[0]  = '{waits: 0, rdata: 32'h0000_0000, stall: 0, op: 2'b00, rs: 32'h0,         addr: 32'h0000_0000, err: 1'b0};
        vecs[1]  = '{waits: 2, rdata: 32'h2001_0005, stall: 0, op: 2'b00, rs: 32'h0,         addr: 32'h0000_0004, err: 1'b0};
        vecs[2]  = '{waits: 5, rdata: 32'h0800_0004, stall: 0, op: 2'b10, rs: 32'h0,         addr: 32'h0000_0008, err: 1'b0};
        vecs[3]  = '{waits: 0, rdata: 32'h1000_FFFF, stall: 0, op: 2'b01, rs: 32'h0,         addr: 32'h0000_0010, err: 1'b0};
        vecs[4]  = '{waits: 1, rdata: 32'h1000_0003, stall: 0, op: 2'b01, rs: 32'h0,         addr: 32'h0000_0010, err: 1'b0};
        vecs[5]  = '{waits: 0, rdata: 32'h0800_0010, stall: 0, op: 2'b10, rs: 32'h0,         addr: 32'h0000_0020, err: 1'b0};
        vecs[6]  = '{waits: 0, rdata: 32'h0800_0100, stall: 4, op: 2'b10, rs: 32'h0,         addr: 32'h0000_0040, err: 1'b0};
        vecs[7]  = '{waits: 0, rdata: 32'h03E0_0008, stall: 0, op: 2'b11, rs: 32'hFFFF_FFFC, addr: 32'h0000_0400, err: 1'b0};
        vecs[8]  = '{waits: 3, rdata: 32'h0000_0020, stall: 0, op: 2'b00, rs: 32'h0,         addr: 32'hFFFF_FFFC, err: 1'b0};
        vecs[9]  = '{waits: 0, rdata: 32'h03E0_0009, stall: 0, op: 2'b11, rs: 32'h0000_0080, addr: 32'h0000_0000, err: 1'b0};
        vecs[10] = '{waits: 0, rdata: 32'h03E0_0008, stall: 1, op: 2'b11, rs: 32'h0000_0082, addr: 32'h0000_0080, err: 1'b1};

        rst        = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        inst_ready = 1'b0;
        npc_op     = 2'b00;
        rs_val     = 32'h0;

        for (int c = 0; c < 3; c++) begin
            imem_ack   = 1'b1;
            inst_ready = 1'b1;
            step();
            chk("rst_req", {31'b0, imem_req}, 32'd0);
            chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        end
        imem_ack   = 1'b0;
        inst_ready = 1'b0;
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_pc_plus4", pc_plus4, 32'h4);
        chk("rst_err", {31'b0, fetch_err}, 32'd0);

        rst = 1'b0;
        chk("idle_no_req", {31'b0, imem_req}, 32'd0);
        step();

        for (int i = 0; i < 11; i++) run_vec(vecs[i]);

        chk("err_pc_kept", imem_addr, 32'h0000_0080);
        for (int c = 0; c < 20; c++) begin
            imem_ack   = 1'b1;
            inst_ready = 1'b1;
            step();
            chk("err_no_req", {31'b0, imem_req}, 32'd0);
            chk("err_no_valid", {31'b0, inst_valid}, 32'd0);
            chk("err_sticky", {31'b0, fetch_err}, 32'd1);
        end
        imem_ack   = 1'b0;
        inst_ready = 1'b0;

        // reset out of ERR, then abandon a request mid-wait
        rst = 1'b1;
        #1;
        chk("rst_clears_err", {31'b0, fetch_err}, 32'd0);
        chk("rst_pc_reload", imem_addr, 32'h0);
        rst = 1'b0;
        step();
        chk("boot2_req", {31'b0, imem_req}, 32'd1);
        step();
        step();
        rst = 1'b1;
        #1;
        chk("midfetch_req_drop", {31'b0, imem_req}, 32'd0);
        rst = 1'b0;
        step();
        chk("restart_req", {31'b0, imem_req}, 32'd1);
        chk("restart_addr", imem_addr, 32'h0);

        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        step();
        imem_ack = 1'b0;
        chk("pre_rst_valid", {31'b0, inst_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midhold_valid_drop", {31'b0, inst_valid}, 32'd0);
        chk("midhold_inst_clr", inst, 32'h0);
        rst = 1'b0;
        step();
        chk("restart2_req", {31'b0, imem_req}, 32'd1);
        chk("restart2_addr", imem_addr, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the single-cycle MIPS core, sitting directly upstream of the decode/control unit. Owns the PC register, issues one word request at a time to instruction memory, and presents the fetched instruction with its PC to decode. Control returns its 2-bit next-PC selection when it consumes the instruction. Fetch then computes the next PC: PC+4, branch, jump or register.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  word address of the request; equals pc.
- imem_ack  in  1  memory returns data this cycle; sampled only while imem_req=1.
- imem_rdata  in  32  instruction word; valid when imem_ack=1.
- inst_valid  out  1  inst/pc outputs hold a fetched instruction.
- inst_ready  in  1  decode consumes the instruction this cycle.
- inst  out  32  fetched instruction (Op = inst[31:26], Funct = inst[5:0]).
- pc_out  out  32  address of inst.
- pc_plus4  out  32  pc_out+4, used as the link value for jal/jalr.
- npc_op  in  2  next-PC select, sampled with inst_ready: 00 PC+4, 01 branch, 10 jump, 11 register. Branch condition is already resolved by control.
- rs_val  in  32  register target for npc_op=11 (jr/jalr).
- fetch_err  out  1  sticky: misaligned register target.

## Operation
- States: IDLE, FETCH, HOLD, ERR.
- IDLE: entered only by reset. Goes to FETCH on the first clock edge with rst=0.
- FETCH: imem_req=1 and imem_addr=pc. Both are held stable until an edge with imem_ack=1. On that edge: inst<=imem_rdata, pc_out<=pc, next state HOLD.
- HOLD: inst_valid=1 and imem_req=0. inst, pc_out and pc_plus4 are stable until an edge with inst_ready=1. On that edge, pc<=next, and the state goes to FETCH, or to ERR on a fault.
- Next-PC arithmetic, all modulo 2^32 (wrap-around allowed):
  - 00: pc+4.
  - 01: pc+4 + ({{14{inst[15]}},inst[15:0],2'b00}).
  - 10: {pc_plus4[31:28], inst[25:0], 2'b00}.
  - 11: rs_val.
- Fault: npc_op=11 with rs_val[1:0]!=0 at consume. fetch_err<=1, pc is unchanged, and the state goes to ERR. ERR is terminal: imem_req=0 and inst_valid=0 until reset.
- inst_ready in FETCH, IDLE or ERR is ignored. npc_op and rs_val are don't-care unless inst_valid & inst_ready.
- imem_ack while imem_req=0 is ignored.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, pc_out=RESET_PC, pc_plus4=RESET_PC+4, fetch_err=0.
- All outputs are registered or decoded from registered state. There are no combinational paths from inputs to outputs.
- First request: imem_req=1 in the first cycle after the first edge with rst=0.
- Zero-wait memory (ack in the first FETCH cycle) gives a throughput of 1 instruction per 2 cycles: FETCH, HOLD, FETCH, ...
- N wait cycles add N cycles to FETCH.
- Latency from the ack edge to inst_valid=1 is 0 cycles; inst_valid is high in the cycle after the ack edge.
- Latency from the consume edge to the next imem_req=1 is 0 cycles; the request is high in the following cycle with the new address.
- Only one request is outstanding; there is no prefetch, so no flush is needed on redirect.
- Reset mid-FETCH abandons the request: imem_req drops immediately. Memory must tolerate an abandoned request.
- Reset mid-HOLD drops inst_valid immediately.

## Test plan
- Reset/boot: hold rst 3 cycles, release -> imem_req=1 and imem_addr=0x0000_0000 in the next cycle. All outputs match the reset values while rst=1.
- Sequential with waits: ack after 0, 2 and 5 wait cycles, inst_ready=1, npc_op=00.
  - Addresses must be 0x0, 0x4, 0x8.
  - imem_addr must be stable during waits.
  - inst_valid must be high exactly 1 cycle each.
- Branch: pc=0x10, inst imm=0x0003, npc_op=01 -> next imem_addr=0x20. With imm=0xFFFF -> 0x10.
- Jump/wrap/backpressure:
  - pc=0x40, inst[25:0]=0x0000100, npc_op=10 -> 0x400.
  - pc=0xFFFF_FFFC, npc_op=00 -> 0x0000_0000.
  - inst_ready low 4 cycles -> inst and pc_out stable, and no request.
- Register target: npc_op=11 with rs_val=0x0000_0080 -> 0x80. Next fetch with rs_val=0x0000_0082 -> fetch_err=1, imem_req stays 0 for 20 cycles, and inst_valid=0.
- Reset mid-operation: assert rst during FETCH with a pending wait, and again during HOLD -> imem_req and inst_valid drop the same cycle, and fetch restarts at RESET_PC after release.
